// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per cycle, round keys on the fly.
// Ports: clk, rst_n, key/key_load/key_ready, ciphertext/in_valid/in_ready,
//        plaintext/out_valid/out_ready. Optional macro: AES_DEC_CLR_OUT_EN.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic         key_load,
    output logic         key_ready,
    input  logic [127:0] ciphertext,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] plaintext,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        READY,
        ROUND,
        DONE
    } st_e;

    st_e          fsm_q;
    logic [127:0] rk10_q;
    logic [127:0] rk_cur_q;
    logic [127:0] state_q;
    logic [127:0] pt_q;
    logic [3:0]   cnt_q;
    logic         key_ready_q;
    logic         in_ready_q;
    logic         out_valid_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // GF(2^8) inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte 4c+r sits at column c, row r; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                             ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                             ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                             ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                             ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Key schedule: the four S-boxes are shared between the forward step
    // (KEYEXP, input w3) and the inverse step (input w3^w2 of the key
    // being walked back: rk10 on accept, rk_cur during rounds).
    logic [127:0] ks_base;
    logic [31:0]  sb_in;
    logic [31:0]  sub_rot;
    logic [31:0]  rc_word;
    logic [3:0]   rc_idx;
    logic [31:0]  fw0, fw1, fw2, fw3;
    logic [31:0]  iw0, iw1, iw2, iw3;
    logic [127:0] ks_fwd_d;
    logic [127:0] ks_inv_d;

    always_comb begin
        ks_base = (fsm_q == READY) ? rk10_q : rk_cur_q;
        sb_in   = (fsm_q == KEYEXP) ? rk_cur_q[31:0]
                                    : (ks_base[31:0] ^ ks_base[63:32]);
        rc_idx  = cnt_q;
        if (fsm_q == KEYEXP) begin
            rc_idx = cnt_q + 4'd1;
        end else if (fsm_q == READY) begin
            rc_idx = 4'd10;
        end
        sub_rot = {sbox(sb_in[23:16]), sbox(sb_in[15:8]),
                   sbox(sb_in[7:0]), sbox(sb_in[31:24])};
        rc_word = {rcon(rc_idx), 24'h000000};

        fw0 = rk_cur_q[127:96] ^ sub_rot ^ rc_word;
        fw1 = rk_cur_q[95:64] ^ fw0;
        fw2 = rk_cur_q[63:32] ^ fw1;
        fw3 = rk_cur_q[31:0] ^ fw2;
        ks_fwd_d = {fw0, fw1, fw2, fw3};

        iw3 = ks_base[31:0] ^ ks_base[63:32];
        iw2 = ks_base[63:32] ^ ks_base[95:64];
        iw1 = ks_base[95:64] ^ ks_base[127:96];
        iw0 = ks_base[127:96] ^ sub_rot ^ rc_word;
        ks_inv_d = {iw0, iw1, iw2, iw3};
    end

    logic [127:0] isb_d;
    logic [127:0] ark_d;
    logic [127:0] imc_d;

    assign isb_d = inv_sub_bytes(inv_shift_rows(state_q));
    assign ark_d = isb_d ^ rk_cur_q;
    assign imc_d = inv_mix_columns(ark_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            rk10_q      <= '0;
            rk_cur_q    <= '0;
            state_q     <= '0;
            pt_q        <= '0;
            cnt_q       <= '0;
            key_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (key_load) begin
                        rk_cur_q <= key;
                        cnt_q    <= '0;
                        fsm_q    <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    if (key_load) begin
                        rk_cur_q <= key;
                        cnt_q    <= '0;
                    end else begin
                        rk_cur_q <= ks_fwd_d;
                        if (cnt_q == 4'd9) begin
                            rk10_q      <= ks_fwd_d;
                            key_ready_q <= 1'b1;
                            in_ready_q  <= 1'b1;
                            fsm_q       <= READY;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                READY: begin
                    // A new key wins over a block offered in the same cycle.
                    if (key_load) begin
                        rk_cur_q    <= key;
                        cnt_q       <= '0;
                        key_ready_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        fsm_q       <= KEYEXP;
                    end else if (in_valid) begin
                        state_q    <= ciphertext ^ rk10_q;
                        rk_cur_q   <= ks_inv_d;
                        cnt_q      <= 4'd9;
                        in_ready_q <= 1'b0;
                        fsm_q      <= ROUND;
                    end
                end
                ROUND: begin
                    if (cnt_q == 4'd0) begin
                        pt_q        <= ark_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        state_q  <= imc_d;
                        rk_cur_q <= ks_inv_d;
                        cnt_q    <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= READY;
`ifdef AES_DEC_CLR_OUT_EN
                        pt_q     <= '0;
                        state_q  <= '0;
                        rk_cur_q <= '0;
`endif
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign plaintext = pt_q;

endmodule
